// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light/state encodings and default durations for traffic_phase_ctrl
package traffic_pkg;

    // Per-phase lamp code as driven on the Lights bus.
    typedef enum logic [1:0] {
        LIGHT_FLASH  = 2'b00,
        LIGHT_GREEN  = 2'b01,
        LIGHT_YELLOW = 2'b10,
        LIGHT_RED    = 2'b11
    } light_e;

    typedef enum logic [1:0] {
        ST_FLASH,
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW
    } state_e;

    localparam int DEF_NUM_PHASES   = 3;
    localparam int DEF_TIMER_W      = 8;
    localparam int DEF_MAIN_GREEN_T = 45;
    localparam int DEF_SIDE_GREEN_T = 15;
    localparam int DEF_YELLOW_T     = 5;
    localparam int DEF_ALLRED_T     = 1;
    localparam int DEF_FLASH_T      = 3;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable tick-driven countdown timer
// Ports:
//   Clock, Reset : clock and asynchronous active-high reset (count <- RESET_VAL)
//   load, value  : load count with value (wins over tick)
//   tick         : decrement strobe, ignored once count reaches 0
//   timeup       : count == 0, combinational
module phase_timer
    import traffic_pkg::*;
#(
    parameter int                   TIMER_W   = DEF_TIMER_W,
    parameter logic [TIMER_W-1:0]   RESET_VAL = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    input  logic               tick,
    output logic               timeup
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeup = (count_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - multi-phase traffic signal controller with main-road rest
// Ports:
//   Clock, Reset : clock and asynchronous active-high reset
//   Tick         : one-cycle timing strobe (one time unit)
//   Sensors      : vehicle-present level per phase
//   Fault        : level forcing fail-safe flash
//   Lights       : 2 bits per phase, phase p at [2p+1:2p] (00 flash, 01 green, 10 yellow, 11 red)
//   CurPhase     : phase currently green/yellow (holds otherwise)
//   Pending      : latched service requests
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES   = DEF_NUM_PHASES,
    parameter int TIMER_W      = DEF_TIMER_W,
    parameter int MAIN_GREEN_T = DEF_MAIN_GREEN_T,
    parameter int SIDE_GREEN_T = DEF_SIDE_GREEN_T,
    parameter int YELLOW_T     = DEF_YELLOW_T,
    parameter int ALLRED_T     = DEF_ALLRED_T,
    parameter int FLASH_T      = DEF_FLASH_T
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Tick,
    input  logic [NUM_PHASES-1:0]   Sensors,
    input  logic                    Fault,
    output logic [2*NUM_PHASES-1:0] Lights,
    output logic [2:0]              CurPhase,
    output logic [NUM_PHASES-1:0]   Pending
);

    localparam longint T_MAX = (longint'(1) << TIMER_W) - 1;

    if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_phases
        $error("traffic_phase_ctrl: NUM_PHASES must be in 2..8");
    end
    if (MAIN_GREEN_T < 0 || MAIN_GREEN_T > T_MAX || SIDE_GREEN_T < 0 || SIDE_GREEN_T > T_MAX ||
        YELLOW_T < 0 || YELLOW_T > T_MAX || ALLRED_T < 0 || ALLRED_T > T_MAX ||
        FLASH_T < 0 || FLASH_T > T_MAX) begin : g_bad_duration
        $error("traffic_phase_ctrl: duration does not fit in TIMER_W bits");
    end

    localparam logic [TIMER_W-1:0] T_MAIN   = TIMER_W'(MAIN_GREEN_T);
    localparam logic [TIMER_W-1:0] T_SIDE   = TIMER_W'(SIDE_GREEN_T);
    localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_T);
    localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_T);
    localparam logic [TIMER_W-1:0] T_FLASH  = TIMER_W'(FLASH_T);

    state_e                  state_q, state_d;
    logic [2:0]              cur_q, cur_d;
    logic [2:0]              last_q, last_d;
    logic [NUM_PHASES-1:0]   pend_q, pend_d;
    logic [NUM_PHASES-1:0]   clr_mask;
    logic [2*NUM_PHASES-1:0] lights_q, lights_d;
    logic [7:0]              pend8;
    logic [2:0]              pick;
    logic                    tmr_load;
    logic [TIMER_W-1:0]      tmr_value;
    logic                    timeup;

    // First pending phase at or after last+1, wrapping; phase 0 when nothing is pending.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
        logic [3:0] cand;
        logic       found;
        rr_pick = 3'd0;
        found   = 1'b0;
        for (int i = 1; i <= NUM_PHASES; i++) begin
            cand = {1'b0, last} + 4'(i);
            if (cand >= 4'(NUM_PHASES)) begin
                cand = cand - 4'(NUM_PHASES);
            end
            if (!found && req[cand[2:0]]) begin
                rr_pick = cand[2:0];
                found   = 1'b1;
            end
        end
    endfunction

    assign pend8 = 8'(pend_q);
    assign pick  = rr_pick(pend8, last_q);

    phase_timer #(
        .TIMER_W   (TIMER_W),
        .RESET_VAL (T_FLASH)
    ) u_timer (
        .Clock  (Clock),
        .Reset  (Reset),
        .load   (tmr_load),
        .value  (tmr_value),
        .tick   (Tick),
        .timeup (timeup)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        tmr_load  = 1'b0;
        tmr_value = T_FLASH;
        clr_mask  = '0;

        if (Fault) begin
            // Holding the timer at FLASH_T guarantees a full flash interval after Fault drops.
            state_d   = ST_FLASH;
            tmr_load  = 1'b1;
            tmr_value = T_FLASH;
        end else begin
            unique case (state_q)
                ST_FLASH: begin
                    if (timeup) begin
                        state_d   = ST_ALL_RED;
                        tmr_load  = 1'b1;
                        tmr_value = T_ALLRED;
                    end
                end
                ST_ALL_RED: begin
                    if (timeup) begin
                        state_d   = ST_GREEN;
                        cur_d     = pick;
                        tmr_load  = 1'b1;
                        tmr_value = (pick == 3'd0) ? T_MAIN : T_SIDE;
                        for (int p = 0; p < NUM_PHASES; p++) begin
                            clr_mask[p] = (pick == 3'(p));
                        end
                    end
                end
                ST_GREEN: begin
                    if (timeup) begin
                        tmr_load = 1'b1;
                        if (cur_q == 3'd0 && !(|pend_q[NUM_PHASES-1:1])) begin
                            // Rest on main road: restart its green without leaving the state.
                            tmr_value = T_MAIN;
                        end else begin
                            state_d   = ST_YELLOW;
                            tmr_value = T_YELLOW;
                        end
                    end
                end
                default: begin
                    if (timeup) begin
                        state_d   = ST_ALL_RED;
                        last_d    = cur_q;
                        tmr_load  = 1'b1;
                        tmr_value = T_ALLRED;
                    end
                end
            endcase
        end

        // Clear wins on the GREEN-entry edge; a still-present sensor re-latches one cycle later.
        pend_d = (pend_q | Sensors) & ~clr_mask;

        // Decoded from the next state so the registered Lights line up with state_q.
        lights_d = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            unique case (state_d)
                ST_FLASH:   lights_d[2*p +: 2] = LIGHT_FLASH;
                ST_ALL_RED: lights_d[2*p +: 2] = LIGHT_RED;
                ST_GREEN:   lights_d[2*p +: 2] = (cur_d == 3'(p)) ? LIGHT_GREEN : LIGHT_RED;
                default:    lights_d[2*p +: 2] = (cur_d == 3'(p)) ? LIGHT_YELLOW : LIGHT_RED;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_FLASH;
            cur_q    <= 3'd0;
            last_q   <= 3'(NUM_PHASES - 1);
            pend_q   <= '0;
            lights_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            lights_q <= lights_d;
        end
    end

    assign Lights   = lights_q;
    assign CurPhase = cur_q;
    assign Pending  = pend_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

    localparam logic [5:0] L_FL = 6'b000000;
    localparam logic [5:0] L_AR = 6'b111111;
    localparam logic [5:0] G0   = 6'b111101;
    localparam logic [5:0] Y0   = 6'b111110;
    localparam logic [5:0] G1   = 6'b110111;
    localparam logic [5:0] Y1   = 6'b111011;
    localparam logic [5:0] G2   = 6'b011111;
    localparam logic [5:0] Y2   = 6'b101111;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Tick = 1'b1;
    logic [2:0] Sensors = 3'b000;
    logic       Fault = 1'b0;
    logic [5:0] Lights;
    logic [2:0] CurPhase;
    logic [2:0] Pending;
    logic [5:0] z_lights;
    logic [2:0] z_cur;
    logic [2:0] z_pend;

    traffic_phase_ctrl dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Tick     (Tick),
        .Sensors  (Sensors),
        .Fault    (Fault),
        .Lights   (Lights),
        .CurPhase (CurPhase),
        .Pending  (Pending)
    );

    // Zero-duration flash and all-red: each must expire on the cycle after entry.
    traffic_phase_ctrl #(
        .FLASH_T  (0),
        .ALLRED_T (0)
    ) dut_zero (
        .Clock    (Clock),
        .Reset    (Reset),
        .Tick     (Tick),
        .Sensors  (3'b000),
        .Fault    (1'b0),
        .Lights   (z_lights),
        .CurPhase (z_cur),
        .Pending  (z_pend)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0] sensors;
        logic       fault;
        int         cycles;
        logic [5:0] lights;
        logic [2:0] cur;
        logic [2:0] pend;
    } seg_t;

    typedef struct {
        logic [5:0] lights;
        logic [2:0] cur;
        logic [2:0] pend;
        int         row;
    } exp_t;

    seg_t segs[$];
    exp_t exp_q[$];
    exp_t sb_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    task automatic add(input logic [2:0] s, input logic f, input int n,
                       input logic [5:0] l, input logic [2:0] c, input logic [2:0] p);
        seg_t r;
        r.sensors = s; r.fault = f; r.cycles = n; r.lights = l; r.cur = c; r.pend = p;
        segs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int green_of(input logic [5:0] l);
        green_of = -1;
        for (int p = 0; p < 3; p++) if (l[2*p +: 2] == 2'b01) green_of = p;
    endfunction

    function automatic int green_count(input logic [5:0] l);
        green_count = 0;
        for (int p = 0; p < 3; p++) if (l[2*p +: 2] == 2'b01) green_count++;
    endfunction

    function automatic logic any_yellow(input logic [5:0] l);
        any_yellow = 1'b0;
        for (int p = 0; p < 3; p++) if (l[2*p +: 2] == 2'b10) any_yellow = 1'b1;
    endfunction

    always @(posedge Clock) cyc++;

    // Scoreboard: each record pushed before an edge is checked just after that edge.
    always @(posedge Clock) begin
        #1;
        if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            n_cmp++;
            if (Lights !== sb_e.lights || CurPhase !== sb_e.cur || Pending !== sb_e.pend) begin
                n_bad++;
                $display("FAIL table row%0d cyc%0d: Lights=%b exp %b CurPhase=%0d exp %0d Pending=%b exp %b",
                         sb_e.row, cyc, Lights, sb_e.lights, CurPhase, sb_e.cur, Pending, sb_e.pend);
            end
        end
    end

    // Safety monitor: single green, and a new green only ever follows all-red.
    int   mon_prev_g = -1;
    logic mon_prev_y = 1'b0;
    int   mon_g;
    always @(negedge Clock) begin
        if (Reset) begin
            mon_prev_g = -1;
            mon_prev_y = 1'b0;
        end else begin
            mon_g = green_of(Lights);
            n_cmp++;
            if (green_count(Lights) > 1 ||
                (mon_g >= 0 && mon_prev_g >= 0 && mon_g != mon_prev_g) ||
                (mon_g >= 0 && mon_prev_y)) begin
                n_bad++;
                $display("FAIL invariant cyc%0d: Lights=%b prev_green=%0d prev_yellow=%b",
                         cyc, Lights, mon_prev_g, mon_prev_y);
            end
            mon_prev_g = mon_g;
            mon_prev_y = any_yellow(Lights);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at cyc%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // sensors, fault, cycles, lights, cur, pend
        add(3'b000, 0,  3, L_FL, 0, 3'b000);  // flash after reset
        add(3'b000, 0,  2, L_AR, 0, 3'b000);
        add(3'b000, 0, 92, G0,   0, 3'b000);  // two main-green periods, resting
        add(3'b100, 0,  1, G0,   0, 3'b100);  // one-cycle pulse on phase 2
        add(3'b000, 0, 45, G0,   0, 3'b100);
        add(3'b000, 0,  6, Y0,   0, 3'b100);
        add(3'b000, 0,  2, L_AR, 0, 3'b100);
        add(3'b000, 0, 16, G2,   2, 3'b000);  // pending[2] cleared on entry
        add(3'b000, 0,  6, Y2,   2, 3'b000);
        add(3'b000, 0,  2, L_AR, 2, 3'b000);
        add(3'b000, 0,  1, G0,   0, 3'b000);  // nothing pending -> main
        add(3'b110, 0,  1, G0,   0, 3'b110);  // phases 1 and 2 together
        add(3'b000, 0, 44, G0,   0, 3'b110);
        add(3'b000, 0,  6, Y0,   0, 3'b110);
        add(3'b000, 0,  2, L_AR, 0, 3'b110);
        add(3'b000, 0, 16, G1,   1, 3'b100);  // 1 before 2
        add(3'b000, 0,  6, Y1,   1, 3'b100);
        add(3'b000, 0,  2, L_AR, 1, 3'b100);
        add(3'b000, 0, 16, G2,   2, 3'b000);
        add(3'b000, 0,  6, Y2,   2, 3'b000);
        add(3'b000, 0,  2, L_AR, 2, 3'b000);
        add(3'b010, 0,  1, G0,   0, 3'b010);  // request phase 1 on main-green entry
        add(3'b000, 0, 45, G0,   0, 3'b010);
        add(3'b000, 0,  6, Y0,   0, 3'b010);
        add(3'b000, 0,  2, L_AR, 0, 3'b010);
        add(3'b000, 0, 16, G1,   1, 3'b000);
        add(3'b000, 0,  2, Y1,   1, 3'b000);
        add(3'b000, 1,  2, L_FL, 1, 3'b000);  // fault during phase-1 yellow
        add(3'b000, 0,  3, L_FL, 1, 3'b000);  // full flash interval after release
        add(3'b000, 0,  2, L_AR, 1, 3'b000);
        add(3'b000, 0,  1, G0,   0, 3'b000);

        repeat (2) @(posedge Clock);
        #1;
        chk("reset_lights", 32'(Lights), 32'(L_FL));
        chk("reset_curphase", 32'(CurPhase), 32'd0);
        chk("reset_pending", 32'(Pending), 32'd0);
        chk("reset_zero_lights", 32'(z_lights), 32'(L_FL));

        @(negedge Clock);
        Reset = 1'b0;
        fork
            begin
                for (int r = 0; r < segs.size(); r++) begin
                    for (int n = 0; n < segs[r].cycles; n++) begin
                        exp_t e;
                        Sensors  = segs[r].sensors;
                        Fault    = segs[r].fault;
                        e.lights = segs[r].lights;
                        e.cur    = segs[r].cur;
                        e.pend   = segs[r].pend;
                        e.row    = r;
                        exp_q.push_back(e);
                        @(negedge Clock);
                    end
                end
            end
            begin
                @(posedge Clock);
                #1;
                chk("zero_flash_expiry", 32'(z_lights), 32'(L_AR));
                @(posedge Clock);
                #1;
                chk("zero_allred_expiry", 32'(z_lights), 32'(G0));
            end
        join
        Sensors = 3'b000;
        Fault   = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a main green with a request pending.
        Sensors = 3'b100;
        @(posedge Clock);
        #1;
        chk("pre_reset_pending", 32'(Pending), 32'b100);
        chk("pre_reset_lights", 32'(Lights), 32'(G0));
        Sensors = 3'b000;
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_lights", 32'(Lights), 32'(L_FL));
        chk("async_reset_pending", 32'(Pending), 32'd0);
        chk("async_reset_curphase", 32'(CurPhase), 32'd0);

        // First green after reset goes to a pending side phase instead of main.
        @(negedge Clock);
        Reset   = 1'b0;
        Sensors = 3'b010;
        @(negedge Clock);
        Sensors = 3'b000;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge Clock);
            #1;
            if (green_of(Lights) >= 0) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL first_green_timeout: Lights=%b no green within 20 cycles", Lights);
        end else begin
            chk("first_green_phase", 32'(CurPhase), 32'd1);
            chk("first_green_lights", 32'(Lights), 32'(G1));
            chk("first_green_pending", 32'(Pending), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
